estagio_id_ex: RTL and testbench
================================

# estagio_id_ex

Upstream neighbour of the ALU: the ID/EX pipeline register plus operand-forwarding and load-use hazard logic of the 5-stage MIPS pipeline. It captures decoded operands and control from ID on each clock edge. It then drives the ALU's `entradaA`, `entradaB` and `ctrlULA`, substituting newer results from EX/MEM or MEM/WB when a source register is still in flight. It also raises `stall` and inserts a bubble on a load-use dependency.

## Interface
- `LARGURA`, 32, datapath width.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `id_rs`, `id_rt`, `id_rd` in 5 each: register numbers decoded in ID.
- `id_dadoA`, `id_dadoB` in LARGURA: register-file read data for rs and rt.
- `id_imediato` in LARGURA: sign-extended immediate.
- `id_ctrlULA` in 4: ALU op code. Encoding: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR.
- `id_usaImediato`, `id_regDst`, `id_memLe`, `id_memEscreve`, `id_escreveReg`, `id_memParaReg` in 1 each: decoded control.
- `flush` in 1: branch/jump taken; discard the instruction in ID.
- `exmem_escreveReg` in 1, `exmem_regDestino` in 5, `exmem_resultado` in LARGURA: EX/MEM write-back info.
- `memwb_escreveReg` in 1, `memwb_regDestino` in 5, `memwb_dado` in LARGURA: MEM/WB write-back info.
- `entradaA`, `entradaB` out LARGURA: ALU operands (forwarded).
- `ctrlULA` out 4: registered ALU op.
- `ex_dadoEscrita` out LARGURA: store data, i.e. forwarded rt value.
- `ex_regDestino` out 5: rd if `regDst` is set, else rt.
- `ex_memLe`, `ex_memEscreve`, `ex_escreveReg`, `ex_memParaReg` out 1 each: registered control, passed to EX/MEM.
- `stall` out 1: hold PC and IF/ID this cycle.

## Operation
- **Registered fields:** rs, rt, rd, dadoA, dadoB, imediato, ctrlULA, and all six control bits.
- **Reset:** while `reset`=0, all registered fields are 0, asynchronously. Resulting outputs:
  - `entradaA` = `entradaB` = `ex_dadoEscrita` = 0
  - `ctrlULA` = 0
  - `ex_regDestino` = 0
  - all `ex_*` control = 0
  - `stall` = 0
- **Load-use hazard:** `stall` = `ex_memLe` & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)). It is combinational from the registered state and the ID inputs.
- **Register update per edge:**
  - If `flush`=1 or `stall`=1: load a bubble. All six control bits and `ctrlULA` are 0; the data/register fields are don't-care but are loaded as 0.
  - Otherwise: load all `id_*` inputs.
  - If `flush` and `stall` are both 1: load a bubble.
- **Forwarding** (combinational, applied separately to operand A using registered rs and to operand B using registered rt):
  - Priority 1: if `exmem_escreveReg` & `exmem_regDestino` != 0 & `exmem_regDestino` == reg, use `exmem_resultado`.
  - Priority 2: else if `memwb_escreveReg` & `memwb_regDestino` != 0 & `memwb_regDestino` == reg, use `memwb_dado`.
  - Otherwise: use the registered dadoA / dadoB.
  - Register 0 is never forwarded.
- **Operand outputs:**
  - `entradaA` = forwarded A.
  - `ex_dadoEscrita` = forwarded B.
  - `entradaB` = registered imediato if `usaImediato`, else forwarded B.
- `ex_regDestino` is selected from the registered rd/rt using the registered `regDst`.

## Timing
- Latency is one cycle: values presented at ID before edge N appear on the outputs after edge N.
- Forwarding and `stall` are zero-latency combinational paths. `stall` depends only on registered state plus the `id_rs`/`id_rt` inputs, not on the forwarding inputs.
- A load-use stall lasts exactly one cycle. After the bubble is registered, `ex_memLe`=0, so `stall` drops. The held instruction is then captured on the next edge, with its operand taken through MEM/WB forwarding.
- A reset asserted mid-stall clears `stall` immediately, because the registered `memLe` is cleared.

## Test plan
- **Reset:** hold `reset`=0 with random inputs. All outputs stay 0. Release, present ADD (ctrl 2, dadoA=5, dadoB=7). After one edge: `entradaA`=5, `entradaB`=7, `ctrlULA`=2.
- **EX/MEM forward:**
  - Registered rs=8. Drive exmem (escreve=1, dest=8, resultado=0x100) and memwb (escreve=1, dest=8, dado=0x200). Expect `entradaA`=0x100.
  - Drop exmem escreve. Expect `entradaA`=0x200.
- **Register 0:** registered rt=0, dadoB=0. Drive exmem dest=0, escreve=1, resultado=0xFFFF. Expect `entradaB`=0; no forward.
- **Load-use:**
  - Registered LW with rt=9 (memLe=1). Drive `id_rs`=9. Expect `stall`=1 that cycle.
  - Next edge: registers hold a bubble (`ex_escreveReg`=0, `ctrlULA`=0) and `stall`=0.
  - Following edge: the instruction is captured; with memwb dest=9, dado=0x33, expect `entradaA`=0x33.
- **Flush:** `flush`=1 with a valid SUB (ctrl 6, escreveReg=1) in ID. After the edge, `ctrlULA`=0 and `ex_escreveReg`=0. Repeat with `stall` also asserted: same bubble.
- **Immediate:** usaImediato=1, imediato=0xFFFFFFFC, rt forwarded from exmem (resultado=0xAA). Expect `entradaB`=0xFFFFFFFC and `ex_dadoEscrita`=0xAA.

Source files
------------

// File: rtl/estagio_id_ex.sv
// ID/EX pipeline register of the 5-stage MIPS pipeline, with operand forwarding
// from EX/MEM and MEM/WB and load-use hazard detection with bubble insertion.
module estagio_id_ex #(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic [4:0]         id_rd,
    input  logic [LARGURA-1:0] id_dadoA,
    input  logic [LARGURA-1:0] id_dadoB,
    input  logic [LARGURA-1:0] id_imediato,
    input  logic [3:0]         id_ctrlULA,
    input  logic               id_usaImediato,
    input  logic               id_regDst,
    input  logic               id_memLe,
    input  logic               id_memEscreve,
    input  logic               id_escreveReg,
    input  logic               id_memParaReg,
    input  logic               flush,
    input  logic               exmem_escreveReg,
    input  logic [4:0]         exmem_regDestino,
    input  logic [LARGURA-1:0] exmem_resultado,
    input  logic               memwb_escreveReg,
    input  logic [4:0]         memwb_regDestino,
    input  logic [LARGURA-1:0] memwb_dado,
    output logic [LARGURA-1:0] entradaA,
    output logic [LARGURA-1:0] entradaB,
    output logic [3:0]         ctrlULA,
    output logic [LARGURA-1:0] ex_dadoEscrita,
    output logic [4:0]         ex_regDestino,
    output logic               ex_memLe,
    output logic               ex_memEscreve,
    output logic               ex_escreveReg,
    output logic               ex_memParaReg,
    output logic               stall
);

    logic [4:0]         rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [LARGURA-1:0] dadoA_q, dadoA_d, dadoB_q, dadoB_d, imed_q, imed_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic               usaImed_q, usaImed_d, regDst_q, regDst_d;
    logic               memLe_q, memLe_d, memEsc_q, memEsc_d;
    logic               escReg_q, escReg_d, memParaReg_q, memParaReg_d;
    logic               stall_s;
    logic [LARGURA-1:0] fwdA_s, fwdB_s;

    // Newest in-flight result wins; register 0 is hardwired and never forwarded.
    function automatic logic [LARGURA-1:0] encaminha(
        input logic [4:0]         reg_n,
        input logic [LARGURA-1:0] base,
        input logic               em_w,
        input logic [4:0]         em_r,
        input logic [LARGURA-1:0] em_v,
        input logic               mw_w,
        input logic [4:0]         mw_r,
        input logic [LARGURA-1:0] mw_v
    );
        logic [LARGURA-1:0] res;
        if (em_w && (em_r != 5'd0) && (em_r == reg_n)) begin
            res = em_v;
        end else if (mw_w && (mw_r != 5'd0) && (mw_r == reg_n)) begin
            res = mw_v;
        end else begin
            res = base;
        end
        return res;
    endfunction

    // Load-use detection: a load in EX whose target is read by the instruction in ID.
    always_comb begin
        stall_s = memLe_q && (rt_q != 5'd0) && ((rt_q == id_rs) || (rt_q == id_rt));
    end

    // Next register contents: a zeroed bubble on flush or stall, else the ID fields.
    always_comb begin
        rs_d = 5'd0;           rt_d = 5'd0;           rd_d = 5'd0;
        dadoA_d = '0;          dadoB_d = '0;          imed_d = '0;
        ctrl_d = 4'd0;         usaImed_d = 1'b0;      regDst_d = 1'b0;
        memLe_d = 1'b0;        memEsc_d = 1'b0;       escReg_d = 1'b0;
        memParaReg_d = 1'b0;
        if (flush || stall_s) begin
            ctrl_d = 4'd0;
        end else begin
            rs_d = id_rs;                 rt_d = id_rt;             rd_d = id_rd;
            dadoA_d = id_dadoA;           dadoB_d = id_dadoB;       imed_d = id_imediato;
            ctrl_d = id_ctrlULA;          usaImed_d = id_usaImediato;
            regDst_d = id_regDst;         memLe_d = id_memLe;       memEsc_d = id_memEscreve;
            escReg_d = id_escreveReg;     memParaReg_d = id_memParaReg;
        end
    end

    // ID/EX pipeline register with asynchronous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rs_q <= 5'd0;          rt_q <= 5'd0;          rd_q <= 5'd0;
            dadoA_q <= '0;         dadoB_q <= '0;         imed_q <= '0;
            ctrl_q <= 4'd0;        usaImed_q <= 1'b0;     regDst_q <= 1'b0;
            memLe_q <= 1'b0;       memEsc_q <= 1'b0;      escReg_q <= 1'b0;
            memParaReg_q <= 1'b0;
        end else begin
            rs_q <= rs_d;          rt_q <= rt_d;          rd_q <= rd_d;
            dadoA_q <= dadoA_d;    dadoB_q <= dadoB_d;    imed_q <= imed_d;
            ctrl_q <= ctrl_d;      usaImed_q <= usaImed_d; regDst_q <= regDst_d;
            memLe_q <= memLe_d;    memEsc_q <= memEsc_d;  escReg_q <= escReg_d;
            memParaReg_q <= memParaReg_d;
        end
    end

    // Operand forwarding and output selection.
    always_comb begin
        fwdA_s = encaminha(rs_q, dadoA_q, exmem_escreveReg, exmem_regDestino, exmem_resultado,
                           memwb_escreveReg, memwb_regDestino, memwb_dado);
        fwdB_s = encaminha(rt_q, dadoB_q, exmem_escreveReg, exmem_regDestino, exmem_resultado,
                           memwb_escreveReg, memwb_regDestino, memwb_dado);
        entradaA       = fwdA_s;
        ex_dadoEscrita = fwdB_s;
        if (usaImed_q) begin
            entradaB = imed_q;
        end else begin
            entradaB = fwdB_s;
        end
        if (regDst_q) begin
            ex_regDestino = rd_q;
        end else begin
            ex_regDestino = rt_q;
        end
    end

    assign ctrlULA       = ctrl_q;
    assign ex_memLe      = memLe_q;
    assign ex_memEscreve = memEsc_q;
    assign ex_escreveReg = escReg_q;
    assign ex_memParaReg = memParaReg_q;
    assign stall         = stall_s;

endmodule

// File: tb/tb_estagio_id_ex.sv
// Self-checking bench for estagio_id_ex: directed scenarios plus randomized
// traffic compared against a transaction-level model of the EX-stage instruction.
module tb_estagio_id_ex;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_dadoA, id_dadoB, id_imediato;
    logic [3:0]  id_ctrlULA;
    logic        id_usaImediato, id_regDst, id_memLe, id_memEscreve, id_escreveReg, id_memParaReg;
    logic        flush;
    logic        exmem_escreveReg, memwb_escreveReg;
    logic [4:0]  exmem_regDestino, memwb_regDestino;
    logic [31:0] exmem_resultado, memwb_dado;
    logic [31:0] entradaA, entradaB, ex_dadoEscrita;
    logic [3:0]  ctrlULA;
    logic [4:0]  ex_regDestino;
    logic        ex_memLe, ex_memEscreve, ex_escreveReg, ex_memParaReg, stall;

    int    n_checks = 0;
    int    n_errors = 0;
    string fase = "init";

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b, imm;
        logic [3:0]  op;
        logic        usa_imm, reg_dst, mem_le, mem_esc, esc_reg, mem_para_reg;
    } instr_t;

    instr_t ex_m;
    instr_t bolha;

    estagio_id_ex #(.LARGURA(32)) dut (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_dadoA(id_dadoA), .id_dadoB(id_dadoB), .id_imediato(id_imediato),
        .id_ctrlULA(id_ctrlULA), .id_usaImediato(id_usaImediato), .id_regDst(id_regDst),
        .id_memLe(id_memLe), .id_memEscreve(id_memEscreve), .id_escreveReg(id_escreveReg),
        .id_memParaReg(id_memParaReg), .flush(flush),
        .exmem_escreveReg(exmem_escreveReg), .exmem_regDestino(exmem_regDestino),
        .exmem_resultado(exmem_resultado),
        .memwb_escreveReg(memwb_escreveReg), .memwb_regDestino(memwb_regDestino),
        .memwb_dado(memwb_dado),
        .entradaA(entradaA), .entradaB(entradaB), .ctrlULA(ctrlULA),
        .ex_dadoEscrita(ex_dadoEscrita), .ex_regDestino(ex_regDestino),
        .ex_memLe(ex_memLe), .ex_memEscreve(ex_memEscreve), .ex_escreveReg(ex_escreveReg),
        .ex_memParaReg(ex_memParaReg), .stall(stall)
    );

    always #5 clock = ~clock;

    task automatic checa(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s [%s]: got %h expected %h", tag, fase, obs, exp);
        end
    endtask

    // Value a register read should see: newest in-flight write to it, if any.
    function automatic logic [31:0] valor_reg(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return rf;
        if (exmem_escreveReg && exmem_regDestino == r) return exmem_resultado;
        if (memwb_escreveReg && memwb_regDestino == r) return memwb_dado;
        return rf;
    endfunction

    function automatic logic modelo_stall();
        return ex_m.mem_le && ex_m.rt != 5'd0 && (ex_m.rt == id_rs || ex_m.rt == id_rt);
    endfunction

    task automatic check_all();
        logic [31:0] b_val;
        b_val = valor_reg(ex_m.rt, ex_m.b);
        checa("entradaA", entradaA, valor_reg(ex_m.rs, ex_m.a));
        checa("entradaB", entradaB, ex_m.usa_imm ? ex_m.imm : b_val);
        checa("dadoEscrita", ex_dadoEscrita, b_val);
        checa("ctrlULA", {28'd0, ctrlULA}, {28'd0, ex_m.op});
        checa("regDestino", {27'd0, ex_regDestino}, {27'd0, (ex_m.reg_dst ? ex_m.rd : ex_m.rt)});
        checa("controle", {28'd0, ex_memLe, ex_memEscreve, ex_escreveReg, ex_memParaReg},
              {28'd0, ex_m.mem_le, ex_m.mem_esc, ex_m.esc_reg, ex_m.mem_para_reg});
        checa("stall", {31'd0, stall}, {31'd0, modelo_stall()});
    endtask

    task automatic ciclo();
        instr_t nova;
        #1;
        check_all();
        @(posedge clock);
        nova.rs = id_rs; nova.rt = id_rt; nova.rd = id_rd;
        nova.a = id_dadoA; nova.b = id_dadoB; nova.imm = id_imediato; nova.op = id_ctrlULA;
        nova.usa_imm = id_usaImediato; nova.reg_dst = id_regDst; nova.mem_le = id_memLe;
        nova.mem_esc = id_memEscreve; nova.esc_reg = id_escreveReg; nova.mem_para_reg = id_memParaReg;
        if (!reset || flush || modelo_stall()) ex_m = bolha;
        else ex_m = nova;
        #1;
        check_all();
    endtask

    task automatic limpa();
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
        id_dadoA = 32'd0; id_dadoB = 32'd0; id_imediato = 32'd0; id_ctrlULA = 4'd0;
        id_usaImediato = 1'b0; id_regDst = 1'b0; id_memLe = 1'b0; id_memEscreve = 1'b0;
        id_escreveReg = 1'b0; id_memParaReg = 1'b0; flush = 1'b0;
        exmem_escreveReg = 1'b0; exmem_regDestino = 5'd0; exmem_resultado = 32'd0;
        memwb_escreveReg = 1'b0; memwb_regDestino = 5'd0; memwb_dado = 32'd0;
    endtask

    task automatic sorteia();
        id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom_range(0, 31));
        id_dadoA = $urandom; id_dadoB = $urandom; id_imediato = $urandom;
        id_ctrlULA = 4'($urandom); id_usaImediato = 1'($urandom); id_regDst = 1'($urandom);
        id_memLe = ($urandom_range(0, 2) == 0); id_memEscreve = 1'($urandom);
        id_escreveReg = 1'($urandom); id_memParaReg = 1'($urandom);
        flush = ($urandom_range(0, 7) == 0);
        exmem_escreveReg = 1'($urandom); exmem_regDestino = 5'($urandom_range(0, 3));
        exmem_resultado = $urandom;
        memwb_escreveReg = 1'($urandom); memwb_regDestino = 5'($urandom_range(0, 3));
        memwb_dado = $urandom;
    endtask

    initial begin
        bolha = '{5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        ex_m = bolha;
        limpa();

        fase = "reset";
        for (int i = 0; i < 4; i++) begin
            sorteia();
            ciclo();
            checa("rst_entradaA", entradaA, 32'd0);
            checa("rst_ctrl", {28'd0, ctrlULA}, 32'd0);
        end
        reset = 1'b1;
        limpa();
        fase = "add";
        id_ctrlULA = 4'd2; id_dadoA = 32'd5; id_dadoB = 32'd7; id_escreveReg = 1'b1;
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_regDst = 1'b1;
        ciclo();
        checa("add_A", entradaA, 32'd5);
        checa("add_B", entradaB, 32'd7);
        checa("add_ctrl", {28'd0, ctrlULA}, 32'd2);

        fase = "fwd";
        limpa();
        id_rs = 5'd8; id_rt = 5'd4; id_dadoA = 32'd1;
        ciclo();
        exmem_escreveReg = 1'b1; exmem_regDestino = 5'd8; exmem_resultado = 32'h100;
        memwb_escreveReg = 1'b1; memwb_regDestino = 5'd8; memwb_dado = 32'h200;
        #1 checa("fwd_exmem", entradaA, 32'h100);
        exmem_escreveReg = 1'b0;
        #1 checa("fwd_memwb", entradaA, 32'h200);

        fase = "reg0";
        limpa();
        ciclo();
        exmem_escreveReg = 1'b1; exmem_regDestino = 5'd0; exmem_resultado = 32'hFFFF;
        #1 checa("reg0_B", entradaB, 32'd0);
        checa("reg0_store", ex_dadoEscrita, 32'd0);

        fase = "loaduse";
        limpa();
        id_memLe = 1'b1; id_rt = 5'd9; id_rs = 5'd1; id_escreveReg = 1'b1; id_memParaReg = 1'b1;
        ciclo();
        limpa();
        id_rs = 5'd9; id_rt = 5'd2; id_ctrlULA = 4'd2; id_escreveReg = 1'b1;
        #1 checa("lu_stall", {31'd0, stall}, 32'd1);
        ciclo();
        checa("lu_bubble_w", {31'd0, ex_escreveReg}, 32'd0);
        checa("lu_bubble_op", {28'd0, ctrlULA}, 32'd0);
        checa("lu_stall_drop", {31'd0, stall}, 32'd0);
        memwb_escreveReg = 1'b1; memwb_regDestino = 5'd9; memwb_dado = 32'h33;
        ciclo();
        checa("lu_fwd", entradaA, 32'h33);
        checa("lu_op", {28'd0, ctrlULA}, 32'd2);

        fase = "flush";
        limpa();
        id_ctrlULA = 4'd6; id_escreveReg = 1'b1; id_rs = 5'd3; id_rt = 5'd4; flush = 1'b1;
        ciclo();
        checa("fl_op", {28'd0, ctrlULA}, 32'd0);
        checa("fl_w", {31'd0, ex_escreveReg}, 32'd0);
        limpa();
        id_memLe = 1'b1; id_rt = 5'd5;
        ciclo();
        limpa();
        id_ctrlULA = 4'd6; id_escreveReg = 1'b1; id_rs = 5'd5; id_rt = 5'd4; flush = 1'b1;
        #1 checa("fl_stall", {31'd0, stall}, 32'd1);
        ciclo();
        checa("flst_op", {28'd0, ctrlULA}, 32'd0);
        checa("flst_w", {31'd0, ex_escreveReg}, 32'd0);

        fase = "imm";
        limpa();
        id_usaImediato = 1'b1; id_imediato = 32'hFFFFFFFC; id_rt = 5'd6; id_dadoB = 32'd1;
        ciclo();
        exmem_escreveReg = 1'b1; exmem_regDestino = 5'd6; exmem_resultado = 32'hAA;
        #1 checa("imm_B", entradaB, 32'hFFFFFFFC);
        checa("imm_store", ex_dadoEscrita, 32'hAA);

        fase = "rst_mid_stall";
        limpa();
        id_memLe = 1'b1; id_rt = 5'd7;
        ciclo();
        limpa();
        id_rs = 5'd7;
        #1 checa("mid_stall_on", {31'd0, stall}, 32'd1);
        reset = 1'b0;
        #1 checa("mid_stall_off", {31'd0, stall}, 32'd0);
        ex_m = bolha;
        reset = 1'b1;

        fase = "random";
        for (int i = 0; i < 300; i++) begin
            sorteia();
            ciclo();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
